// File: rtl/rainbow_frame_gen.sv
// Colour-wheel frame builder: one LED per cycle into a shadow buffer, committed atomically.
// Latency: step sampled at edge k -> packed_rgb_data/frame_done update at edge k+NUM_LEDS+1.
module rainbow_frame_gen #(
    parameter int NUM_LEDS    = 8,
    parameter int HUE_STEP    = 1,
    parameter int LED_SPACING = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step,
    input  logic [7:0]              brightness,
    output logic [24*NUM_LEDS-1:0]  packed_rgb_data,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [7:0]       HUE_INC  = 8'(HUE_STEP);
    localparam logic [7:0]       HUE_SPC  = 8'(LED_SPACING);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t           state_q, state_d;
    logic             start;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       base_hue_q;
    logic [7:0]       led_hue_q;
    logic [7:0]       bright_q;
    logic [23:0]      shadow [NUM_LEDS];

    // Three-segment colour wheel, returned as {G,R,B}.
    function automatic logic [23:0] wheel_grb(input logic [7:0] h);
        logic [7:0] w;
        logic [7:0] up;
        w  = 8'h00;
        up = 8'h00;
        if (h < 8'd85) begin
            up = (h << 1) + h;
            return {8'h00, 8'hFF - up, up};
        end else if (h < 8'd170) begin
            w  = h - 8'd85;
            up = (w << 1) + w;
            return {up, 8'h00, 8'hFF - up};
        end else begin
            w  = h - 8'd170;
            up = (w << 1) + w;
            return {8'hFF - up, up, 8'h00};
        end
    endfunction

    // (c * (b+1)) >> 8 so that b = 255 is an exact pass-through.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = {9'd0, c} * ({9'd0, b} + 17'd1);
        return p[15:8];
    endfunction

    function automatic logic [23:0] pixel(input logic [7:0] h, input logic [7:0] b);
        logic [23:0] grb;
        grb = wheel_grb(h);
        return {scale(grb[23:16], b), scale(grb[15:8], b), scale(grb[7:0], b)};
    endfunction

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (step) begin
                    state_d = CALC;
                    start   = 1'b1;
                end
            end
            CALC:    if (idx_q == IDX_LAST) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            base_hue_q      <= 8'h00;
            frame_done      <= 1'b0;
            packed_rgb_data <= '0;
        end else begin
            state_q    <= state_d;
            frame_done <= (state_q == COMMIT);
            if (start)
                idx_q <= '0;
            else if (state_q == CALC)
                idx_q <= idx_q + 1'b1;
            if (state_q == COMMIT) begin
                base_hue_q <= base_hue_q + HUE_INC;
                for (int i = 0; i < NUM_LEDS; i++)
                    packed_rgb_data[24*i +: 24] <= shadow[i];
            end
        end
    end

    // Datapath: brightness and hue are captured at acceptance, so late input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (start) begin
            bright_q  <= brightness;
            led_hue_q <= base_hue_q;
        end else if (state_q == CALC) begin
            shadow[idx_q] <= pixel(led_hue_q, bright_q);
            led_hue_q     <= led_hue_q + HUE_SPC;
        end
    end

endmodule

// File: tb/tb_rainbow_frame_gen.sv
// Scoreboard bench for rainbow_frame_gen: stimulus queues expected frames, a monitor checks each commit.
module tb_rainbow_frame_gen;

    localparam int N = 8;

    // base_hue 0, brightness FF: hues 0,32,...,224 (LED7 leftmost)
    localparam logic [191:0] F0 = {24'h5DA200, 24'hBD4200, 24'hE1001E, 24'h81007E,
                                   24'h2100DE, 24'h003FC0, 24'h009F60, 24'h00FF00};
    // base_hue 1, brightness FF: hues 1,33,...,225
    localparam logic [191:0] F1 = {24'h5AA500, 24'hBA4500, 24'hE4001B, 24'h84007B,
                                   24'h2400DB, 24'h003CC3, 24'h009C63, 24'h00FC03};
    // base_hue 0, brightness 7F: every channel halved (floor)
    localparam logic [191:0] FH = {24'h2E5100, 24'h5E2100, 24'h70000F, 24'h40003F,
                                   24'h10006F, 24'h001F60, 24'h004F30, 24'h007F00};

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           step = 1'b0;
    logic [7:0]     brightness = 8'hFF;
    logic [24*N-1:0] packed_rgb_data;
    logic           busy;
    logic           frame_done;

    rainbow_frame_gen #(.NUM_LEDS(N), .HUE_STEP(1), .LED_SPACING(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .step           (step),
        .brightness     (brightness),
        .packed_rgb_data(packed_rgb_data),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [191:0] frame;
        bit           chk;
        int           exp_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   frames_seen = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every frame_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (frame_done) begin
            frames_seen++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done actual=cycle%0d required=none", cyc);
            end else begin
                e = sb.pop_front();
                chk("frame_done_cycle", 192'(cyc), 192'(e.exp_cyc));
                if (e.chk)
                    for (int i = 0; i < N; i++)
                        chk($sformatf("led%0d", i), {168'd0, packed_rgb_data[24*i +: 24]},
                            {168'd0, e.frame[24*i +: 24]});
            end
        end
    end

    task automatic issue(input logic [191:0] f, input bit c);
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        sb.push_back('{f, c, cyc + N + 1});
    endtask

    task automatic wait_done();
        int start_cnt;
        int n;
        start_cnt = frames_seen;
        n = 0;
        while (frames_seen == start_cnt && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (frames_seen == start_cnt) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout actual=none required=frame_done");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_packed", packed_rgb_data, '0);
        chk("reset_busy", {191'd0, busy}, '0);
        chk("reset_frame_done", {191'd0, frame_done}, '0);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state, then idle with step low: nothing may commit.
        do_reset();
        repeat (12) @(negedge clk);
        chk("idle_packed", packed_rgb_data, '0);

        // Half brightness, changed to full mid-build: frame must stay at half.
        brightness = 8'h7F;
        issue(FH, 1'b1);
        repeat (3) @(posedge clk);
        brightness = 8'hFF;
        wait_done();

        // Fresh reset, full brightness, with an ignored step while busy.
        do_reset();
        issue(F0, 1'b1);
        chk("busy_after_step", {191'd0, busy}, 192'd1);
        repeat (3) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_done();
        repeat (12) @(negedge clk);
        chk("busy_idle", {191'd0, busy}, '0);
        issue(F1, 1'b1);
        wait_done();

        // Frames 3..256 (base 2..255), then frame 257 wraps back to base 0.
        for (int f = 0; f < 254; f++) begin
            issue('0, 1'b0);
            wait_done();
        end
        issue(F0, 1'b1);
        wait_done();

        // Reset while building LED 4: output clears, nothing commits.
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_packed", packed_rgb_data, '0);
        chk("midreset_busy", {191'd0, busy}, '0);
        chk("midreset_frame_done", {191'd0, frame_done}, '0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midreset_hold", packed_rgb_data, '0);
        issue(F0, 1'b1);
        wait_done();

        chk("scoreboard_empty", 192'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
